noise_gate: RTL



---
 rtl/noise_gate.sv | 96 +++++++++
 1 files changed

// File: rtl/noise_gate.sv
// noise_gate: peak-envelope noise gate with hysteresis, hold timer and linear gain ramp, two-stage pipeline.
module noise_gate #(
  parameter int GAIN_FRAC     = 8,
  parameter int RAMP_STEP     = 16,
  parameter int RELEASE_SHIFT = 6,
  parameter int HOLD_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] signal_in,
  input  logic [15:0]        threshold,
  input  logic [HOLD_W-1:0]  hold_samples,
  output logic               out_valid,
  output logic signed [15:0] signal_out,
  output logic               gate_open
);
  localparam int GW = GAIN_FRAC + 1;
  localparam logic [GW-1:0] UNITY = GW'(1 << GAIN_FRAC);
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
  typedef enum logic [2:0] {CLOSED, OPENING, OPEN, HOLD, CLOSING} state_t;
  state_t state, state_mid, state_nxt;
  logic [16:0] env, env_dec, env_new, mag;
  logic [15:0] abs_in;
  logic above, below;
  logic [GW-1:0] gain, gain_new;
  logic [GW:0] gain_up;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic signed [15:0] sample, sat;
  logic signed [25:0] prod, scaled;
  logic v1;
  assign abs_in = signal_in == 16'sh8000 ? 16'h7fff : (signal_in[15] ? 16'(-signal_in) : signal_in);
  assign mag = {1'b0, abs_in};
  assign env_dec = env - (env >> RELEASE_SHIFT);
  assign env_new = mag > env_dec ? mag : env_dec;
  assign above = env_new >= {1'b0, threshold};
  assign below = env_new < {2'b0, threshold[15:1]};
  assign gain_up = {1'b0, gain} + {1'b0, STEP};
  always_comb begin
    state_mid = state;
    hold_nxt = hold_cnt;
    case (state)
      CLOSED:  if (above) state_mid = OPENING;
      OPENING: if (below) state_mid = CLOSING;
      OPEN: if (below) begin
        hold_nxt = hold_samples;
        if (hold_samples == '0) state_mid = CLOSING;
        else state_mid = HOLD;
      end
      HOLD: if (above) state_mid = OPEN;
      else begin
        hold_nxt = hold_cnt - 1'b1;
        if (hold_cnt == HOLD_W'(1)) state_mid = CLOSING;
      end
      CLOSING: if (above) state_mid = OPENING;
      default: state_mid = CLOSED;
    endcase
  end
  // gain follows the state we are heading into; ramp endpoints then settle the state
  always_comb begin
    gain_new = state_mid == OPEN || state_mid == HOLD ? UNITY
             : state_mid == OPENING ? (gain_up >= {1'b0, UNITY} ? UNITY : gain_up[GW-1:0])
             : state_mid == CLOSING ? (gain <= STEP ? '0 : gain - STEP)
             : '0;
    state_nxt = state_mid;
    if (state_mid == OPENING && gain_new == UNITY) state_nxt = OPEN;
    if (state_mid == CLOSING && gain_new == '0) state_nxt = CLOSED;
  end
  assign prod = sample * $signed({1'b0, gain});
  assign scaled = prod >>> GAIN_FRAC;
  assign sat = scaled > 26'sd32767 ? 16'sh7fff : scaled < -26'sd32768 ? 16'sh8000 : scaled[15:0];
  assign gate_open = state != CLOSED;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLOSED;
      env <= '0;
      gain <= '0;
      hold_cnt <= '0;
      sample <= '0;
      v1 <= 1'b0;
      out_valid <= 1'b0;
      signal_out <= '0;
    end else begin
      v1 <= in_valid;
      out_valid <= v1;
      if (v1) signal_out <= sat;
      if (in_valid) begin
        state <= state_nxt;
        env <= env_new;
        gain <= gain_new;
        hold_cnt <= hold_nxt;
        sample <= signal_in;
      end
    end
  end
endmodule
